vec_strided_load_unit: RTL and testbench

//  Memory-side stage of the vector coprocessor for vles_varp (strided, variable-precision load).

---
 rtl/vec_strided_load_unit.sv | 189 ++++++++++++++++++
 tb/tb_vec_strided_load_unit.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_strided_load_unit.sv
// vec_strided_load_unit
//   Memory-side stage of the vector coprocessor for the strided,
//   variable-precision load (vles_varp). It walks a_i = base_addr + i*stride
//   over the 32-bit memory port, extracts a vap-bit element from each
//   addressed word and packs element i at vreg_wdata[i*vap +: vap].
//
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   start               command strobe, accepted only in IDLE
//   base_addr, stride   byte address of element 0, signed byte stride
//   vl, vap             element count, element width (1,2,4,8,16,32)
//   busy, done, err     status; done/err are single-cycle pulses
//   vreg_wdata          packed result, valid on done, held until next start
//   mem_*               read-only memory port (wdata/wstrb tied to 0)
//
// Optional feature
//   VSLU_WORD_REUSE_EN  when defined, an element whose word matches the last
//                       fetched word is extracted without a new request.
//
// state     | meaning
// S_IDLE    | waiting for start
// S_CHECK   | decide: finish, error, fetch or reuse for element i
// S_REQ     | mem_valid high, waiting for mem_ready
// S_EXTRACT | insert element i, advance address and index
// S_DONE    | done pulse
// S_ERR     | err pulse (illegal vap or misaligned element)
module vec_strided_load_unit #(
    parameter int VLEN = 256,
    parameter int VL_W = 9
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            start,
    input  logic [31:0]     base_addr,
    input  logic [31:0]     stride,
    input  logic [VL_W-1:0] vl,
    input  logic [5:0]      vap,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [VLEN-1:0] vreg_wdata,
    output logic            mem_valid,
    input  logic            mem_ready,
    output logic [31:0]     mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic [31:0]     mem_rdata
);

    localparam int LOG_VLEN = $clog2(VLEN);
    // Counter wide enough for both vl and VLEN (the element count at vap=1).
    localparam int CW = (VL_W > LOG_VLEN + 1) ? VL_W : LOG_VLEN + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_REQ, S_EXTRACT, S_DONE, S_ERR
    } state_t;

    state_t          state_q, state_d;

    logic [31:0]     cur_addr;
    logic [31:0]     stride_q;
    logic [VL_W-1:0] vl_q;
    logic [5:0]      vap_q;
    logic [CW-1:0]   idx;
    logic [31:0]     rdata_q;

    logic            vap_legal;
    logic            misaligned;
    logic            reuse_hit;
    logic [CW-1:0]   max_cnt;
    logic [CW-1:0]   n_eff;
    logic [CW-1:0]   idx_inc;
    logic [CW+5:0]   bit_off;
    logic [31:0]     word_sh;
    logic [31:0]     elem_mask;
    logic [31:0]     elem;
    logic [VLEN-1:0] vreg_next;

`ifdef VSLU_WORD_REUSE_EN
    logic [29:0]     last_word;
    logic            last_valid;
`endif

    always_comb begin
        vap_legal = 1'b1;
        max_cnt   = '0;
        case (vap_q)
            6'd1:    max_cnt = CW'(VLEN);
            6'd2:    max_cnt = CW'(VLEN / 2);
            6'd4:    max_cnt = CW'(VLEN / 4);
            6'd8:    max_cnt = CW'(VLEN / 8);
            6'd16:   max_cnt = CW'(VLEN / 16);
            6'd32:   max_cnt = CW'(VLEN / 32);
            default: vap_legal = 1'b0;
        endcase
        n_eff      = (CW'(vl_q) < max_cnt) ? CW'(vl_q) : max_cnt;
        misaligned = ((vap_q == 6'd16) && cur_addr[0]) ||
                     ((vap_q == 6'd32) && (cur_addr[1:0] != 2'b00));
        idx_inc    = idx + 1'b1;
        bit_off    = (CW+6)'(idx) * (CW+6)'(vap_q);
        // Same formula covers vap<8: the low vap bits of the addressed byte.
        word_sh    = rdata_q >> {cur_addr[1:0], 3'b000};
        elem_mask  = (vap_q >= 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << vap_q) - 32'd1);
        elem       = word_sh & elem_mask;
        vreg_next  = vreg_wdata | ({{(VLEN-32){1'b0}}, elem} << bit_off);
`ifdef VSLU_WORD_REUSE_EN
        reuse_hit  = last_valid && (last_word == cur_addr[31:2]);
`else
        reuse_hit  = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (start) state_d = S_CHECK;
            S_CHECK: begin
                if (!vap_legal)          state_d = S_ERR;
                else if (n_eff == '0)    state_d = S_DONE;
                else if (misaligned)     state_d = S_ERR;
                else if (reuse_hit)      state_d = S_EXTRACT;
                else                     state_d = S_REQ;
            end
            S_REQ:     if (mem_ready) state_d = S_EXTRACT;
            S_EXTRACT: state_d = (idx_inc == n_eff) ? S_DONE : S_CHECK;
            S_DONE:    state_d = S_IDLE;
            S_ERR:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cur_addr   <= '0;
            stride_q   <= '0;
            vl_q       <= '0;
            vap_q      <= '0;
            idx        <= '0;
            rdata_q    <= '0;
            vreg_wdata <= '0;
`ifdef VSLU_WORD_REUSE_EN
            last_word  <= '0;
            last_valid <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cur_addr   <= base_addr;
                        stride_q   <= stride;
                        vl_q       <= vl;
                        vap_q      <= vap;
                        idx        <= '0;
                        vreg_wdata <= '0;
`ifdef VSLU_WORD_REUSE_EN
                        last_valid <= 1'b0;
`endif
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        rdata_q    <= mem_rdata;
`ifdef VSLU_WORD_REUSE_EN
                        last_word  <= cur_addr[31:2];
                        last_valid <= 1'b1;
`endif
                    end
                end
                S_EXTRACT: begin
                    vreg_wdata <= vreg_next;
                    idx        <= idx_inc;
                    cur_addr   <= cur_addr + stride_q;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = (state_q == S_ERR);
    assign mem_valid = (state_q == S_REQ);
    assign mem_addr  = {cur_addr[31:2], 2'b00};
    assign mem_wdata = '0;
    assign mem_wstrb = '0;

endmodule

// File: tb/tb_vec_strided_load_unit.sv
// Bench for vec_strided_load_unit: directed cases with literal expectations,
// then randomized commands checked against a per-element address model.
module tb_vec_strided_load_unit;

    localparam int VLEN = 256;
    localparam int VL_W = 9;
`ifdef VSLU_WORD_REUSE_EN
    localparam bit REUSE = 1'b1;
`else
    localparam bit REUSE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            resetn;
    logic            start;
    logic [31:0]     base_addr;
    logic [31:0]     stride;
    logic [VL_W-1:0] vl;
    logic [5:0]      vap;
    logic            busy, done, err;
    logic [VLEN-1:0] vreg_wdata;
    logic            mem_valid;
    logic            mem_ready;
    logic            mem_ready_auto;
    logic            mem_ready_man;
    logic [31:0]     mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_wstrb;

    assign mem_ready = mem_ready_auto | mem_ready_man;

    always #5 clk = ~clk;

    vec_strided_load_unit #(.VLEN(VLEN), .VL_W(VL_W)) dut (
        .clk(clk), .resetn(resetn), .start(start),
        .base_addr(base_addr), .stride(stride), .vl(vl), .vap(vap),
        .busy(busy), .done(done), .err(err), .vreg_wdata(vreg_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int req_cnt  = 0;

    logic [31:0]     mem_ov [logic [29:0]];
    logic [31:0]     exp_q [$];
    logic            exp_err;
    logic [VLEN-1:0] exp_vreg;
    bit              cmd_active = 1'b0;
    bit              cmd_ended  = 1'b0;
    logic            prev_valid = 1'b0;
    logic [31:0]     prev_addr  = '0;

    task automatic check(input string name, input logic [VLEN-1:0] got, input logic [VLEN-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        if (mem_ov.exists(wa)) return mem_ov[wa];
        return {wa[13:0], 2'b01, wa[29:14]} ^ 32'hA5C3_5A3C;
    endfunction

    // Expected request list and final vector, element by element, bit by bit.
    task automatic model(input logic [31:0] b, input logic [31:0] s, input int vli, input int vp);
        int          n;
        int          off;
        logic [31:0] a;
        logic [31:0] w;
        bit          rv;
        logic [29:0] rwa;
        bit          hit;
        exp_q.delete();
        exp_err  = 1'b0;
        exp_vreg = '0;
        rv  = 1'b0;
        rwa = '0;
        if (!(vp inside {1, 2, 4, 8, 16, 32})) begin
            exp_err = 1'b1;
            return;
        end
        n = (vli < VLEN / vp) ? vli : VLEN / vp;
        a = b;
        for (int i = 0; i < n; i++) begin
            if ((vp == 16 && a[0]) || (vp == 32 && a[1:0] != 2'b00)) begin
                exp_err = 1'b1;
                return;
            end
            hit = REUSE && rv && (rwa == a[31:2]);
            if (!hit) begin
                exp_q.push_back({a[31:2], 2'b00});
                rv  = 1'b1;
                rwa = a[31:2];
            end
            w   = mem_word(a[31:2]);
            off = 8 * int'(a[1:0]);
            for (int k = 0; k < vp; k++) exp_vreg[i*vp + k] = w[off + k];
            a = a + s;
        end
    endtask

    // Memory: answers with mem_ready after mem_valid has been seen for lat cycles.
    initial begin
        int seen;
        seen = 0;
        mem_ready_auto = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (mem_valid && !mem_ready_auto) begin
                if (seen >= lat) begin
                    mem_ready_auto = 1'b1;
                    mem_rdata = mem_word(mem_addr[31:2]);
                    seen = 0;
                end else begin
                    seen++;
                end
            end else begin
                mem_ready_auto = 1'b0;
                mem_rdata = $urandom;
                seen = 0;
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (resetn === 1'b1) begin
            if (mem_valid && !prev_valid) begin
                req_cnt++;
                check("req_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("req_addr", mem_addr, exp_q.pop_front());
                check("req_tied", {mem_wdata, mem_wstrb}, 0);
            end else if (mem_valid) begin
                check("req_hold", mem_addr, prev_addr);
            end
            if (done || err) begin
                check("end_expected", cmd_active && !cmd_ended, 1);
                check("err_flag", err, exp_err);
                check("done_flag", done, !exp_err);
                check("vreg", vreg_wdata, exp_vreg);
                cmd_ended = 1'b1;
            end
        end
        prev_valid = mem_valid;
        prev_addr  = mem_addr;
    end

    task automatic run_cmd(input logic [31:0] b, input logic [31:0] s, input int vli, input int vp,
                           input int lat_i, input bit inject, input bit start_at_done,
                           output int cyc, output bit saw_err);
        model(b, s, vli, vp);
        lat       = lat_i;
        req_cnt   = 0;
        base_addr = b;
        stride    = s;
        vl        = VL_W'(vli);
        vap       = 6'(vp);
        start     = 1'b1;
        cmd_active = 1'b1;
        cmd_ended  = 1'b0;
        @(negedge clk);
        start     = 1'b0;
        base_addr = $urandom;
        stride    = $urandom;
        vl        = VL_W'($urandom);
        vap       = 6'($urandom);
        cyc = 1;
        check("busy_after_start", busy, 1);
        while (!(done || err) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = inject && (cyc == 3);
        end
        saw_err = err;
        check("busy_at_end", busy, 1);
        start = start_at_done;
        @(negedge clk);
        start = 1'b0;
        check("cmd_ended", cmd_ended, 1);
        check("req_left", exp_q.size(), 0);
        check("busy_released", busy, 0);
        check("vreg_held", vreg_wdata, exp_vreg);
        cmd_active = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc;
        bit          se;
        int          vp, vli, r;
        logic [31:0] b, s;

        resetn = 1'b0; start = 1'b0; base_addr = '0; stride = '0; vl = '0; vap = '0;
        mem_ready_man = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_status", {busy, done, err, mem_valid}, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_vreg", vreg_wdata, 0);
        resetn = 1'b1;
        @(negedge clk);

        mem_ov[30'd100] = 32'h0403_0201;
        mem_ov[30'd101] = 32'h0807_0605;
        mem_ov[30'd102] = 32'h0C0B_0A09;

        // T1
        run_cmd(32'd400, 32'd1, 4, 8, 1, 1'b0, 1'b0, cyc, se);
        check("t1_vreg", vreg_wdata, 256'h0403_0201);
        check("t1_reqs", req_cnt, REUSE ? 1 : 4);
        check("t1_cycles", cyc, REUSE ? 11 : 17);
        // T2
        run_cmd(32'd400, 32'd4, 3, 8, 1, 1'b0, 1'b0, cyc, se);
        check("t2_vreg", vreg_wdata, 256'h09_0501);
        check("t2_reqs", req_cnt, 3);
        // T3
        run_cmd(32'd401, 32'd1, 2, 4, 0, 1'b0, 1'b0, cyc, se);
        check("t3a_vreg", vreg_wdata, 256'h32);
        check("t3a_reqs", req_cnt, REUSE ? 1 : 2);
        run_cmd(32'd400, 32'hFFFF_FFFC, 1, 32, 2, 1'b0, 1'b0, cyc, se);
        check("t3b_vreg", vreg_wdata, 256'h0403_0201);
        // T4
        run_cmd(32'd402, 32'd1, 2, 16, 1, 1'b0, 1'b0, cyc, se);
        check("t4_err", se, 1);
        check("t4_vreg", vreg_wdata, 256'h0403);
        check("t4_reqs", req_cnt, 1);
        // T5, plus a start coincident with done
        run_cmd(32'd400, 32'd1, 0, 8, 1, 1'b0, 1'b1, cyc, se);
        check("t5_vl0_cycles", cyc, 2);
        check("t5_vl0_reqs", req_cnt, 0);
        check("t5_vl0_done", se, 0);
        @(negedge clk);
        check("start_at_done_ignored", {busy, done, err}, 0);
        run_cmd(32'd400, 32'd1, 4, 3, 1, 1'b0, 1'b0, cyc, se);
        check("t5_vap3_err", se, 1);
        check("t5_vap3_reqs", req_cnt, 0);

        // T6: reset while a request is outstanding
        model(32'd400, 32'd1, 4, 8);
        lat = 1; base_addr = 32'd400; stride = 32'd1; vl = VL_W'(4); vap = 6'd8;
        cmd_active = 1'b1; cmd_ended = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!mem_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_valid_seen", mem_valid, 1);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_reset_status", {mem_valid, busy, done, err}, 0);
        check("t6_reset_vreg", vreg_wdata, 0);
        resetn = 1'b1;
        exp_q.delete();
        cmd_active = 1'b0;
        mem_ready_man = 1'b1;
        @(negedge clk);
        mem_ready_man = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t6_late_ready_ignored", {busy, done, err, mem_valid}, 0);
        end
        run_cmd(32'd400, 32'd1, 4, 8, 1, 1'b0, 1'b0, cyc, se);
        check("t6_t1_vreg", vreg_wdata, 256'h0403_0201);

        // Randomized commands
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 13);
            vli = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 24);
            if (r < 12) begin
                vp = 1 << (r % 6);
            end else begin
                vp = $urandom_range(0, 63);
                while (vp inside {1, 2, 4, 8, 16, 32}) vp = $urandom_range(0, 63);
                if (vli == 0) vli = 1;
            end
            b = $urandom;
            if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
            case ($urandom_range(0, 3))
                0:       s = 32'($urandom_range(0, 32)) - 32'd16;
                1:       s = 32'($urandom_range(0, 8)) << 2;
                2:       s = 32'd0 - (32'($urandom_range(0, 8)) << 2);
                default: s = $urandom;
            endcase
            run_cmd(b, s, vli, vp, $urandom_range(0, 3), (k % 5) == 2, 1'b0, cyc, se);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
